// File: rtl/cnt_enable_scheduler_pkg.sv
// Shared types and constants for the counting-enable scheduler.
// Optional feature macro: CNT_SCHED_STARVE_EN (starvation wait counters).
package cnt_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2
   } sched_state_e;

   // Wait counter width and saturation point used by the starvation guard
   localparam int unsigned WAIT_W = 8;
   localparam logic [WAIT_W-1:0] STARVE_THRESH = 8'd255;

   // Gap counter width (GAP is limited to 0..3)
   localparam int unsigned GAP_W = 2;

   // Width of an index into n requesters, never narrower than one bit
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cnt_enable_scheduler_if.sv
// Request/enable bundle between the control logic and the scheduler.
// Optional feature macro: CNT_SCHED_STARVE_EN adds starve_flag.
interface cnt_enable_scheduler_if
   import cnt_sched_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned LW   = 4
) ();

   localparam int unsigned IDW = id_width(NREQ);

   logic [NREQ-1:0] req;
   logic [LW-1:0]   burst_len;
   logic [NREQ-1:0] on;
   logic [IDW-1:0]  grant_id;
   logic            busy;
   logic [NREQ-1:0] done;
`ifdef CNT_SCHED_STARVE_EN
   logic [NREQ-1:0] starve_flag;
`endif

   // Control side: raises requests and observes enables
   modport master (
      output req, burst_len,
`ifdef CNT_SCHED_STARVE_EN
      input  starve_flag,
`endif
      input  on, grant_id, busy, done
   );

   // Scheduler side
   modport slave (
      input  req, burst_len,
`ifdef CNT_SCHED_STARVE_EN
      output starve_flag,
`endif
      output on, grant_id, busy, done
   );

endinterface

// File: rtl/cnt_enable_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr_i.
module rr_arbiter_onehot
   import cnt_sched_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = id_width(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] sel_oh_c,
   output logic [IDW-1:0]  sel_idx_c,
   output logic            valid_c
);

   // Scan (ptr+1) mod NREQ onwards, wrapping back to ptr itself last
   always_comb begin
      int unsigned pos;
      logic        found;
      sel_oh_c  = '0;
      sel_idx_c = '0;
      found     = 1'b0;
      pos       = 0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         pos = (32'(ptr_i) + k) % NREQ;
         if (!found && req_i[pos[IDW-1:0]]) begin
            found                     = 1'b1;
            sel_idx_c                 = pos[IDW-1:0];
            sel_oh_c[pos[IDW-1:0]]    = 1'b1;
         end
      end
      valid_c = found;
   end

endmodule

// File: rtl/cnt_enable_scheduler.sv
// Round-robin scheduler granting one counter slice its enable at a time.
// Optional feature macro: CNT_SCHED_STARVE_EN (per-slice wait counters that
// preempt round-robin once saturated, plus starve_flag output).
module cnt_enable_scheduler
   import cnt_sched_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned LW   = 4,
   parameter int unsigned GAP  = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   cnt_enable_scheduler_if.slave  bus
);

   localparam int unsigned IDW = id_width(NREQ);

   sched_state_e    state_q, state_d;
   logic [LW-1:0]   cnt_q, cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [NREQ-1:0] on_q, on_d;
   logic [IDW-1:0]  gid_q, gid_d;
   logic [NREQ-1:0] done_q, done_d;
   logic            busy_q, busy_d;

   logic [NREQ-1:0] rr_oh_c;
   logic [IDW-1:0]  rr_idx_c;
   logic            rr_valid_c;
   logic [NREQ-1:0] sel_oh_c;
   logic [IDW-1:0]  sel_idx_c;
   logic            sel_valid_c;

   rr_arbiter_onehot #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req_i     (bus.req),
      .ptr_i     (ptr_q),
      .sel_oh_c  (rr_oh_c),
      .sel_idx_c (rr_idx_c),
      .valid_c   (rr_valid_c)
   );

`ifdef CNT_SCHED_STARVE_EN
   logic [WAIT_W-1:0] wait_q [NREQ];
   logic [WAIT_W-1:0] wait_d [NREQ];
   logic [NREQ-1:0]   starved_c;
   logic [NREQ-1:0]   flag_q, flag_d;

   // Requesters whose wait counter has saturated
   always_comb begin
      starved_c = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         starved_c[k] = bus.req[k] && (wait_q[k] == STARVE_THRESH);
      end
   end

   // Starved slices override round-robin, lowest index first
   always_comb begin
      sel_oh_c    = rr_oh_c;
      sel_idx_c   = rr_idx_c;
      sel_valid_c = rr_valid_c;
      if (|starved_c) begin
         sel_oh_c    = '0;
         sel_valid_c = 1'b1;
         for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (starved_c[k]) begin
               sel_idx_c = IDW'(k);
            end
         end
         sel_oh_c[sel_idx_c] = 1'b1;
      end
   end

   // Saturating wait counters; cleared on the grant of their slice
   always_comb begin
      for (int unsigned k = 0; k < NREQ; k++) begin
         wait_d[k] = wait_q[k];
         if ((state_q == ST_IDLE) && sel_valid_c && sel_oh_c[k]) begin
            wait_d[k] = '0;
         end else if (bus.req[k] && !on_q[k] && (wait_q[k] != STARVE_THRESH)) begin
            wait_d[k] = wait_q[k] + WAIT_W'(1);
         end
         flag_d[k] = (wait_d[k] == STARVE_THRESH);
      end
   end

   // Wait counter and flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            wait_q[k] <= '0;
         end
         flag_q <= '0;
      end else begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            wait_q[k] <= wait_d[k];
         end
         flag_q <= flag_d;
      end
   end

   assign bus.starve_flag = flag_q;
`else
   // Pure round-robin selection
   always_comb begin
      sel_oh_c    = rr_oh_c;
      sel_idx_c   = rr_idx_c;
      sel_valid_c = rr_valid_c;
   end
`endif

   // Next-state and output decode for IDLE -> RUN -> (GAP) -> IDLE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      ptr_d   = ptr_q;
      on_d    = on_q;
      gid_d   = gid_q;
      done_d  = '0;
      case (state_q)
         ST_IDLE: begin
            if (sel_valid_c) begin
               on_d    = sel_oh_c;
               gid_d   = sel_idx_c;
               ptr_d   = sel_idx_c;
               // A zero length grant is stretched to one cycle
               cnt_d   = (bus.burst_len == '0) ? LW'(1) : bus.burst_len;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cnt_q <= LW'(1)) begin
               on_d   = '0;
               done_d = on_q;
               cnt_d  = '0;
               if (GAP > 0) begin
                  gap_d   = GAP_W'(GAP);
                  state_d = ST_GAP;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - LW'(1);
            end
         end
         ST_GAP: begin
            if (gap_q <= GAP_W'(1)) begin
               gap_d   = '0;
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         default: begin
            on_d    = '0;
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs; reset gives slice 0 first priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         gap_q   <= '0;
         ptr_q   <= IDW'(NREQ - 1);
         on_q    <= '0;
         gid_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         ptr_q   <= ptr_d;
         on_q    <= on_d;
         gid_q   <= gid_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.on       = on_q;
   assign bus.grant_id = gid_q;
   assign bus.done     = done_q;
   assign bus.busy     = busy_q;

endmodule
